// File: rtl/apb_pkg.sv
// Shared types and constants for the APB wait-state completer.
// The LFSR constants are only used when RANDOM_WAIT_EN is defined.
package apb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int WAIT_W     = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/apb_wait_lfsr.sv
// 8-bit Fibonacci LFSR used as a random wait-state source.
// Exposes only the two low bits that select 0..3 wait states.
module apb_wait_lfsr
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] rand_bits
);

  logic [7:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign rand_bits = lfsr_reg[1:0];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a small register memory, programmable wait states and
// out-of-range error reporting. Define RANDOM_WAIT_EN for LFSR-driven waits.
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > (1 << WAIT_W) - 1) begin : g_bad_wait
    $error("apb_wait_slave: WAIT_CYCLES must be in 0..15");
  end

  state_t              state_reg;
  logic [WAIT_W-1:0]   cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                write_reg;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [WAIT_W-1:0]   wait_load;
  logic                completing;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

`ifdef RANDOM_WAIT_EN
  logic [1:0] rand_bits;

  apb_wait_lfsr u_lfsr (
    .clk       (PCLK),
    .rst       (PRESET),
    .en        (1'b1),
    .rand_bits (rand_bits)
  );

  assign wait_load = {2'b00, rand_bits};
`else
  assign wait_load = WAIT_W'(WAIT_CYCLES);
`endif

  assign in_range   = 32'(addr_reg) < MEM_DEPTH;
  assign idx        = addr_reg[IDX_W-1:0];
  assign completing = (state_reg == ST_ACCESS) && (cnt_reg == '0) && PSEL && PENABLE;

  // Responses exist only in the completing cycle; everything else reads as zero
  assign PREADY  = completing;
  assign PSLVERR = completing && !in_range;
  assign PRDATA  = (completing && in_range && !write_reg) ? mem[idx] : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_reg  <= PADDR;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            cnt_reg   <= wait_load;
            state_reg <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_reg <= ST_IDLE;
          end else if (PENABLE) begin
            if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
            else               state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_mem
    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        mem[gi] <= '0;
      end else if (completing && write_reg && in_range && (32'(idx) == gi)) begin
        mem[gi] <= wdata_reg;
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Self-checking bench for apb_wait_slave: vector table, hand-written corner
// sequences and a randomized phase against a memory/latency reference model.
module tb_apb_wait_slave;

  logic       clk = 1'b0;
  logic       PRESET;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA, PRDATA0;
  logic       PREADY, PSLVERR, PREADY0, PSLVERR0;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [256];
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  apb_wait_slave #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(2)) u_dut (
    .PCLK(clk), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_wait_slave #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0)
  );

  // Reference LFSR straight from the polynomial x^8+x^6+x^5+x^4
  always @(posedge clk or posedge PRESET) begin
    if (PRESET) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_wait_now();
`ifdef RANDOM_WAIT_EN
    return int'(lfsr_m[1:0]);
`else
    return 2;
`endif
  endfunction

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  // One APB transfer; leaves the bus in its completing cycle so a following
  // call issues its setup cycle back-to-back.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output bit err);
    int  waits;
    int  exp_w;
    bit  quiet;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    exp_w = exp_wait_now();
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    quiet = 1'b1;
    @(negedge clk);
`ifndef RANDOM_WAIT_EN
    chk("zero_wait_ready", int'(PREADY0), 1);
`endif
    while (!PREADY && waits <= 40) begin
      if (PRDATA !== 8'h00 || PSLVERR !== 1'b0) quiet = 1'b0;
      waits++;
      @(posedge clk); #1;
      // Bus lines other than PSEL/PENABLE must be ignored during access
      PADDR = 8'($urandom); PWDATA = 8'($urandom); PWRITE = 1'($urandom);
      @(negedge clk);
    end
    if (waits > 40) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for PREADY addr=%0h", a);
    end
    chk("wait_states", waits, exp_w);
    chk("quiet_while_waiting", int'(quiet), 1);
    rd  = PRDATA;
    err = PSLVERR;
    $display("xfer %s addr=%02h wdata=%02h waits=%0d rdata=%02h slverr=%0d",
             w ? "WR" : "RD", a, d, waits, rd, err);
  endtask

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    bit         err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] rd;
    bit         err;
    int         n;

    tbl[0] = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h10, 8'h3C, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 8'h10, 8'h00, 8'h3C, 1'b0};
    tbl[3] = '{1'b1, 8'h80, 8'hFF, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 8'h7F, 8'h5A, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 8'h7F, 8'h00, 8'h5A, 1'b0};
    tbl[8] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
    tbl[9] = '{1'b1, 8'h00, 8'hC3, 8'h00, 1'b0};

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", int'(PREADY), 0);
    chk("reset_prdata", int'(PRDATA), 0);
    chk("reset_pslverr", int'(PSLVERR), 0);
    @(posedge clk); #1;
    PRESET = 1'b0;

    // Vector table, applied back-to-back
    foreach (tbl[i]) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, rd, err);
      chk($sformatf("tbl%0d_rdata", i), int'(rd), int'(tbl[i].rd));
      chk($sformatf("tbl%0d_slverr", i), int'(err), int'(tbl[i].err));
      if (tbl[i].w && tbl[i].a < 8'h80) model_mem[tbl[i].a] = tbl[i].d;
    end
    bus_idle(1);

    // PENABLE without a setup cycle must be ignored
    @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b1;
    @(posedge clk); #1; PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h10; PWRITE = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (PREADY !== 1'b0 || PREADY0 !== 1'b0 || PRDATA !== 8'h00) n++;
      @(posedge clk); #1;
    end
    chk("penable_in_idle_ignored", n, 0);
    $display("seq penable_in_idle responses=%0d", n);
    bus_idle(1);

    // Abort: setup write, one access cycle, then drop PSEL
    @(posedge clk); #1; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 8'hAA;
    @(posedge clk); #1; PENABLE = 1'b1;
    @(negedge clk);
    chk("abort_wait_ready", int'(PREADY), 0);
    @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    chk("abort_no_ready", int'(PREADY), 0);
    $display("seq abort write addr=20");
    xfer(1'b0, 8'h20, 8'h00, rd, err);
    chk("abort_read_back", int'(rd), 0);
    bus_idle(1);

    // Reset in the completing cycle of a write: write must be dropped
    @(posedge clk); #1; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'hAA;
    @(posedge clk); #1; PENABLE = 1'b1;
    @(negedge clk);
    n = 0;
    while (!PREADY && n < 40) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("rst_pre_ready", int'(PREADY), 1);
    #1 PRESET = 1'b1;
    #1;
    chk("rst_mid_pready", int'(PREADY), 0);
    chk("rst_mid_pslverr", int'(PSLVERR), 0);
    chk("rst_mid_prdata", int'(PRDATA), 0);
    $display("seq reset during write addr=01");
    @(posedge clk); #1; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1; PRESET = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    xfer(1'b0, 8'h01, 8'h00, rd, err);
    chk("rst_read_back", int'(rd), 0);
    xfer(1'b0, 8'h10, 8'h00, rd, err);
    chk("rst_cleared_mem", int'(rd), 0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      bit         w;
      logic [7:0] a, d, erd;
      bit         eerr;
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 8'h7F;
      d = 8'($urandom);
      eerr = (a >= 8'h80);
      erd  = (!w && !eerr) ? model_mem[a] : 8'h00;
      xfer(w, a, d, rd, err);
      chk("rand_rdata", int'(rd), int'(erd));
      chk("rand_slverr", int'(err), int'(eerr));
      if (w && !eerr) model_mem[a] = d;
      bus_idle($urandom_range(0, 2));
    end
    bus_idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
